// File: rtl/led_pkg.sv
// Shared types and helpers for the APA102/SK9822 LED strip serializer.
package led_pkg;

  typedef enum logic [2:0] {IDLE, SOF, LED, EOF, WAIT} led_ser_state_t;

  localparam int SOF_BITS = 32;

  // The end frame needs half a clock edge per LED to flush the daisy chain, never less than one word.
  function automatic int end_bits(input int led_num);
    int b;
    b = 8 * ((led_num + 15) / 16);
    return (b < 32) ? 32 : b;
  endfunction

  function automatic logic [7:0] expand_color(input logic [7:0] c, input int w);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[7-i] = c[w-1-(i%w)];
    end
    return r;
  endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Divides clk into LED-clock periods; the counter freezes while the serializer stalls.
module led_bit_timer #(
  parameter int DIV_CNT = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run_i,
  input  logic                       stall_i,
  output logic [$clog2(DIV_CNT)-1:0] div_cnt_o,
  output logic                       cko_o,
  output logic                       bit_strobe_o
);

  localparam int DW = $clog2(DIV_CNT);

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (!run_i) begin
      div_d = '0;
    end else if (!stall_i) begin
      div_d = (div_q == DW'(DIV_CNT - 1)) ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign div_cnt_o    = div_q;
  assign cko_o        = run_i && (div_q >= DW'(DIV_CNT / 2));
  assign bit_strobe_o = run_i && !stall_i && (div_q == DW'(DIV_CNT - 1));

endmodule

// File: rtl/led_strip_serializer.sv
// APA102/SK9822 frame serializer: SOF zeros, one 32-bit word per pixel, EOF ones, then idle gap.
module led_strip_serializer
  import led_pkg::*;
#(
  parameter int LED_NUM     = 35,
  parameter int COLOR_W     = 4,
  parameter int DIV_CNT     = 5,
  parameter int WAIT_CNT    = 5,
  parameter int COLOR_ORDER = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4:0]             brightness,
  input  logic                   pix_valid,
  input  logic [3*COLOR_W-1:0]   pix_data,
  output logic                   pix_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   underrun,
  output logic                   cko,
  output logic                   sdo
);

  localparam int END_BITS = end_bits(LED_NUM);
  localparam int LW = $clog2(LED_NUM + 1);
  localparam int EW = $clog2(END_BITS + 1);
  localparam int WW = $clog2(WAIT_CNT + 1);
  localparam int DW = $clog2(DIV_CNT);

  led_ser_state_t state_q, state_d;
  logic [4:0]     bit_q, bit_d;
  logic [LW-1:0]  led_q, led_d;
  logic [EW-1:0]  eof_q, eof_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [31:0]    shift_q, shift_d;
  logic [4:0]     bright_q, bright_d;
  logic           sdo_q;

  logic          run, boundary, stall, fire, bit_strobe;
  logic [DW-1:0] div_cnt;
  logic [7:0]    red, green, blue;
  logic [31:0]   pix_word;

  assign run      = (state_q == SOF) || (state_q == LED) || (state_q == EOF);
  assign boundary = (state_q == LED) && (div_cnt == '0) && (bit_q == '0);
  assign stall    = boundary && !pix_valid;
  assign fire     = boundary && pix_valid;

  led_bit_timer #(.DIV_CNT(DIV_CNT)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .run_i        (run),
    .stall_i      (stall),
    .div_cnt_o    (div_cnt),
    .cko_o        (cko),
    .bit_strobe_o (bit_strobe)
  );

  assign red      = expand_color(8'(pix_data[3*COLOR_W-1:2*COLOR_W]), COLOR_W);
  assign green    = expand_color(8'(pix_data[2*COLOR_W-1:COLOR_W]), COLOR_W);
  assign blue     = expand_color(8'(pix_data[COLOR_W-1:0]), COLOR_W);
  assign pix_word = (COLOR_ORDER == 1) ? {3'b111, bright_q, red, green, blue}
                                       : {3'b111, bright_q, blue, green, red};

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    led_d    = led_q;
    eof_d    = eof_q;
    wait_d   = wait_q;
    shift_d  = shift_q;
    bright_d = bright_q;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SOF;
          bright_d = brightness;
          bit_d    = '0;
        end
      end
      SOF: begin
        if (bit_strobe) begin
          if (bit_q == 5'(SOF_BITS - 1)) begin
            state_d = LED;
            bit_d   = '0;
            led_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      LED: begin
        if (fire) begin
          shift_d = pix_word;
        end
        if (bit_strobe) begin
          shift_d = {shift_q[30:0], 1'b0};
          if (bit_q == 5'd31) begin
            bit_d = '0;
            if (led_q == LW'(LED_NUM - 1)) begin
              state_d = EOF;
              eof_d   = '0;
            end else begin
              led_d = led_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      EOF: begin
        if (bit_strobe) begin
          if (eof_q == EW'(END_BITS - 1)) begin
            state_d = WAIT;
            wait_d  = '0;
          end else begin
            eof_d = eof_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (wait_q == WW'(WAIT_CNT - 1)) begin
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // While waiting for a pixel the line keeps the previous bit; the word's leading 1 goes out with the handshake.
  always_comb begin
    sdo = 1'b0;
    case (state_q)
      LED:     sdo = boundary ? (pix_valid ? 1'b1 : sdo_q) : shift_q[31];
      EOF:     sdo = 1'b1;
      default: sdo = 1'b0;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign pix_ready = boundary;
  assign underrun  = stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      led_q    <= '0;
      eof_q    <= '0;
      wait_q   <= '0;
      shift_q  <= '0;
      bright_q <= '0;
      sdo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      led_q    <= led_d;
      eof_q    <= eof_d;
      wait_q   <= wait_d;
      shift_q  <= shift_d;
      bright_q <= bright_d;
      sdo_q    <= sdo;
    end
  end

endmodule

// File: tb/tb_led_strip_serializer.sv
// Bench for led_strip_serializer: decodes the cko/sdo stream and compares it with frames built from the driven pixels.
module tb_led_strip_serializer;

  localparam int A_FRAME = (32 + 32 * 2 + 32) * 4 + 5;
  localparam int C_BITS  = 32 + 32 * 600 + 304;
  localparam int C_FRAME = C_BITS * 2 + 5 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        startA, pixValidA, pixReadyA, busyA, doneA, underA, ckoA, sdoA;
  logic [4:0]  brightA;
  logic [11:0] pixDataA;
  logic        startC, pixValidC, pixReadyC, busyC, doneC, underC, ckoC, sdoC;
  logic [4:0]  brightC;
  logic [23:0] pixDataC;

  led_strip_serializer #(.LED_NUM(2), .COLOR_W(4), .DIV_CNT(4), .WAIT_CNT(5), .COLOR_ORDER(0)) dutA (
    .clk(clk), .rst(rst), .start(startA), .brightness(brightA), .pix_valid(pixValidA),
    .pix_data(pixDataA), .pix_ready(pixReadyA), .busy(busyA), .done(doneA),
    .underrun(underA), .cko(ckoA), .sdo(sdoA)
  );

  led_strip_serializer #(.LED_NUM(600), .COLOR_W(8), .DIV_CNT(2), .WAIT_CNT(5), .COLOR_ORDER(1)) dutC (
    .clk(clk), .rst(rst), .start(startC), .brightness(brightC), .pix_valid(pixValidC),
    .pix_data(pixDataC), .pix_ready(pixReadyC), .busy(busyC), .done(doneC),
    .underrun(underC), .cko(ckoC), .sdo(sdoC)
  );

  int errors = 0;
  int checks = 0;

  // Monitors: the LED latches sdo on the rising edge of cko, so that is where a bit is recorded.
  logic bitsA[$];
  logic bitsC[$];
  bit   ckoPrevA = 1'b0, ckoPrevC = 1'b0;
  int   hsA = 0, doneCntA = 0, underCntA = 0, underCkoA = 0;
  int   hsC = 0, doneCntC = 0, underCntC = 0;

  always @(negedge clk) begin
    if (ckoA && !ckoPrevA) bitsA.push_back(sdoA);
    ckoPrevA = ckoA;
    if (pixValidA && pixReadyA) hsA++;
    if (doneA) doneCntA++;
    if (underA) begin
      underCntA++;
      if (ckoA) underCkoA++;
    end
  end

  always @(negedge clk) begin
    if (ckoC && !ckoPrevC) bitsC.push_back(sdoC);
    ckoPrevC = ckoC;
    if (pixValidC && pixReadyC) hsC++;
    if (doneC) doneCntC++;
    if (underC) underCntC++;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: n-bit colour replicated to 8 bits is a multiply by 0x11 for 4-bit input.
  function automatic logic [7:0] expand4(input logic [3:0] c);
    return 8'(c) * 8'h11;
  endfunction

  function automatic logic [31:0] modelWordA(input logic [4:0] br, input logic [11:0] p);
    return {3'b111, br, expand4(p[3:0]), expand4(p[7:4]), expand4(p[11:8])};
  endfunction

  function automatic logic [31:0] getWordA(input int s);
    logic [31:0] w;
    w = 'x;
    for (int i = 0; i < 32; i++) if (s + i < bitsA.size()) w[31-i] = bitsA[s+i];
    return w;
  endfunction

  function automatic logic [31:0] getWordC(input int s);
    logic [31:0] w;
    w = 'x;
    for (int i = 0; i < 32; i++) if (s + i < bitsC.size()) w[31-i] = bitsC[s+i];
    return w;
  endfunction

  int bBits, bHs, bDone, bUnder, bUnderCko;

  task automatic snapBases();
    bBits = bitsA.size(); bHs = hsA; bDone = doneCntA; bUnder = underCntA; bUnderCko = underCkoA;
  endtask

  // Runs one frame on instance A; stallLen cycles of missing pixel are inserted before the second word.
  task automatic applyStimulus(input logic [4:0] br, input logic [11:0] p0, input logic [11:0] p1,
                               input int stallLen, input bit randValid, input bit pokeStart,
                               output int frameLen);
    logic [11:0] px[2];
    int idx, left, t0;
    bit finished;
    px[0] = p0; px[1] = p1; idx = 0; left = stallLen; finished = 1'b0; frameLen = -1;
    snapBases();
    startA = 1'b1; brightA = br; t0 = cyc;
    for (int t = 0; t < 5000 && !finished; t++) begin
      @(posedge clk); #1;
      startA  = pokeStart && (t % 9 == 4);
      brightA = 5'($urandom);
      if (idx >= 2) begin
        pixValidA = 1'b0;
      end else if (idx == 1 && left > 0) begin
        pixValidA = 1'b0;
        if (pixReadyA) left--;
      end else begin
        pixDataA  = px[idx];
        pixValidA = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pixValidA && pixReadyA) idx++;
      end
      if (doneA) begin
        frameLen = cyc - t0;
        finished = 1'b1;
        if (pokeStart) startA = 1'b1;
      end
    end
    @(posedge clk); #1;
    startA = 1'b0; pixValidA = 1'b0;
    checkOutput("doneSeenA", 64'(finished), 64'd1);
    checkOutput("busyAfterDoneA", 64'(busyA), 64'd0);
  endtask

  task automatic checkFrameA(input string tag, input logic [31:0] exp0, input logic [31:0] exp1,
                             input int stallLen, input bit randValid, input int frameLen);
    checkOutput($sformatf("%s.bits", tag), 64'(bitsA.size() - bBits), 64'd128);
    checkOutput($sformatf("%s.sof", tag), 64'(getWordA(bBits)), 64'h0);
    checkOutput($sformatf("%s.led0", tag), 64'(getWordA(bBits + 32)), 64'(exp0));
    checkOutput($sformatf("%s.led1", tag), 64'(getWordA(bBits + 64)), 64'(exp1));
    checkOutput($sformatf("%s.eof", tag), 64'(getWordA(bBits + 96)), 64'hFFFF_FFFF);
    checkOutput($sformatf("%s.handshakes", tag), 64'(hsA - bHs), 64'd2);
    checkOutput($sformatf("%s.doneCount", tag), 64'(doneCntA - bDone), 64'd1);
    checkOutput($sformatf("%s.ckoDuringUnderrun", tag), 64'(underCkoA - bUnderCko), 64'd0);
    if (!randValid) begin
      checkOutput($sformatf("%s.underrunCycles", tag), 64'(underCntA - bUnder), 64'(stallLen));
      checkOutput($sformatf("%s.frameLen", tag), 64'(frameLen), 64'(A_FRAME + stallLen));
    end
  endtask

  typedef struct {
    logic [4:0]  br;
    logic [11:0] p0;
    logic [11:0] p1;
    int          stall;
    bit          randValid;
    bit          poke;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int len, bC, hC, uC, dC, t0C, ones, reached, lenC;
    bit finishedC;
    logic [4:0]  br;
    logic [11:0] p0, p1;
    int st;
    bit rv;

    rst = 1'b1;
    startA = 1'b0; brightA = '0; pixValidA = 1'b0; pixDataA = '0;
    startC = 1'b0; brightC = '0; pixValidC = 1'b0; pixDataC = '0;

    vecs[0] = '{5'h1F, 12'hA50, 12'h0F1, 0,  1'b0, 1'b0, 32'hFF00_55AA, 32'hFF11_FF00};
    vecs[1] = '{5'h1F, 12'hA50, 12'h0F1, 20, 1'b0, 1'b0, 32'hFF00_55AA, 32'hFF11_FF00};
    vecs[2] = '{5'h00, 12'hFFF, 12'h000, 0,  1'b0, 1'b1, 32'hE0FF_FFFF, 32'hE000_0000};
    vecs[3] = '{5'h0A, 12'h123, 12'h8C4, 0,  1'b1, 1'b0, 32'hEA33_2211, 32'hEA44_CC88};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetA", 64'({pixReadyA, busyA, doneA, underA, ckoA, sdoA}), 64'd0);
    checkOutput("resetC", 64'({pixReadyC, busyC, doneC, underC, ckoC, sdoC}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("postResetA", 64'({pixReadyA, busyA, doneA, underA, ckoA, sdoA}), 64'd0);

    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].br, vecs[v].p0, vecs[v].p1, vecs[v].stall, vecs[v].randValid, vecs[v].poke, len);
      repeat (20) @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d.idleBusy", v), 64'(busyA), 64'd0);
      checkFrameA($sformatf("vec%0d", v), vecs[v].exp0, vecs[v].exp1, vecs[v].stall, vecs[v].randValid, len);
    end

    for (int r = 0; r < 6; r++) begin
      br = 5'($urandom); p0 = 12'($urandom); p1 = 12'($urandom);
      st = $urandom_range(0, 10); rv = 1'($urandom_range(0, 1));
      applyStimulus(br, p0, p1, st, rv, 1'b0, len);
      repeat (5) @(posedge clk);
      #1;
      checkFrameA($sformatf("rand%0d", r), modelWordA(br, p0), modelWordA(br, p1), st, rv, len);
    end

    // Abort in the middle of the pixel words, with a start pulse during reset that must be ignored.
    snapBases();
    startA = 1'b1; brightA = 5'h11; pixValidA = 1'b1; pixDataA = 12'h5A5;
    @(posedge clk); #1;
    startA = 1'b0;
    reached = 0;
    for (int t = 0; t < 1000 && reached == 0; t++) begin
      @(posedge clk); #1;
      if (bitsA.size() >= bBits + 40) reached = 1;
    end
    checkOutput("abort.reachedLed", 64'(reached), 64'd1);
    rst = 1'b1; startA = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort.outputs", 64'({pixReadyA, busyA, doneA, underA, ckoA, sdoA}), 64'd0);
    rst = 1'b0; startA = 1'b0; pixValidA = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort.staysIdle", 64'(busyA), 64'd0);
    checkOutput("abort.noDone", 64'(doneCntA - bDone), 64'd0);
    applyStimulus(5'h1F, 12'hA50, 12'h0F1, 0, 1'b0, 1'b0, len);
    repeat (5) @(posedge clk);
    #1;
    checkFrameA("afterAbort", 32'hFF00_55AA, 32'hFF11_FF00, 0, 1'b0, len);

    // Long strip: EOF length and whole-frame timing with an always-ready source.
    bC = bitsC.size(); hC = hsC; uC = underCntC; dC = doneCntC;
    pixValidC = 1'b1; pixDataC = 24'h123456; brightC = 5'h0C; startC = 1'b1; t0C = cyc;
    finishedC = 1'b0; lenC = -1;
    for (int t = 0; t < 45000 && !finishedC; t++) begin
      @(posedge clk); #1;
      startC = 1'b0;
      if (doneC) begin
        finishedC = 1'b1;
        lenC = cyc - t0C + 1;
      end
    end
    pixValidC = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("C.doneSeen", 64'(finishedC), 64'd1);
    checkOutput("C.frameLen", 64'(lenC), 64'(C_FRAME));
    checkOutput("C.bits", 64'(bitsC.size() - bC), 64'(C_BITS));
    checkOutput("C.led0", 64'(getWordC(bC + 32)), 64'hEC12_3456);
    checkOutput("C.handshakes", 64'(hsC - hC), 64'd600);
    checkOutput("C.underrun", 64'(underCntC - uC), 64'd0);
    checkOutput("C.doneCount", 64'(doneCntC - dC), 64'd1);
    ones = 0;
    for (int i = bitsC.size() - 1; i >= bC && bitsC[i] == 1'b1; i--) ones++;
    checkOutput("C.eofBits", 64'(ones), 64'd304);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
